// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cordic_pkg
// Description : Shared constants and helpers for the vectoring-mode CORDIC
//               polar analyzer: arctangent table, gain-compensation shifts,
//               FSM state encoding and a positive-saturation helper.
// Revision    : 1.0  initial release
// ============================================================================
package cordic_pkg;

  // Index width for the micro-rotation counter and table lookups (up to 16 steps)
  localparam int c_idx_w = 4;

  // Fractional precision of the stored arctangent table
  localparam int c_atan_frac = 16;

  // Shift amounts approximating the CORDIC gain 1/1.6468 = 0.6074
  localparam int c_gain_sh0 = 1;
  localparam int c_gain_sh1 = 3;
  localparam int c_gain_sh2 = 6;
  localparam int c_gain_sh3 = 9;

  // FSM state encoding
  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_iter  = 2'd1;
  localparam logic [1:0] c_st_scale = 2'd2;

  // round(atan(2^-i)/pi * 2^16)
  function automatic int atan_q16(input logic [c_idx_w-1:0] idx);
    case (idx)
      4'd0:    return 16384;
      4'd1:    return 9672;
      4'd2:    return 5110;
      4'd3:    return 2594;
      4'd4:    return 1302;
      4'd5:    return 652;
      4'd6:    return 326;
      4'd7:    return 163;
      4'd8:    return 81;
      4'd9:    return 41;
      4'd10:   return 20;
      4'd11:   return 10;
      4'd12:   return 5;
      4'd13:   return 3;
      4'd14:   return 1;
      default: return 1;
    endcase
  endfunction

  // Table entry reduced to n_frac fractional bits with round-half-up
  function automatic int atan_round(input logic [c_idx_w-1:0] idx, input int n_frac);
    return (atan_q16(idx) + (1 << (c_atan_frac - 1 - n_frac))) >>> (c_atan_frac - n_frac);
  endfunction

  // Largest positive value of a signed quantity of the given width
  function automatic int sat_pos(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_vectoring_step.sv
`default_nettype none
// ============================================================================
// Module      : cordic_vectoring_step
// Description : Combinational single vectoring-mode CORDIC micro-rotation.
//               Rotates (x, y) toward the positive x axis by atan(2^-i) and
//               accumulates the rotated angle into z.
// Ports       : i_x, i_y   signed IW-bit vector in
//               i_z        signed angle in (N_FRAC+1 bits, wraps)
//               i_idx      micro-rotation index i
//               o_x, o_y   rotated vector
//               o_z        updated angle
// Revision    : 1.0  initial release
// ============================================================================
module cordic_vectoring_step
  import cordic_pkg::*;
#(
  parameter int N_FRAC = 7,
  parameter int IW     = N_FRAC + 3
) (
  input  logic signed [IW-1:0]     i_x,
  input  logic signed [IW-1:0]     i_y,
  input  logic signed [N_FRAC:0]   i_z,
  input  logic [c_idx_w-1:0]       i_idx,
  output logic signed [IW-1:0]     o_x,
  output logic signed [IW-1:0]     o_y,
  output logic signed [N_FRAC:0]   o_z
);

  localparam int W = N_FRAC + 1;

  logic signed [IW-1:0] w_xs;
  logic signed [IW-1:0] w_ys;
  logic signed [W-1:0]  w_atan;

  assign w_xs   = i_x >>> i_idx;
  assign w_ys   = i_y >>> i_idx;
  assign w_atan = W'(atan_round(i_idx, N_FRAC));

  // Rotate against the sign of y so y is driven toward zero.
  // z is allowed to wrap: +pi and -pi are the same angle.
  always_comb begin
    o_x = i_x;
    o_y = i_y;
    o_z = i_z;
    if (!i_y[IW-1]) begin
      o_x = i_x + w_ys;
      o_y = i_y - w_xs;
      o_z = i_z + w_atan;
    end else begin
      o_x = i_x - w_ys;
      o_y = i_y + w_xs;
      o_z = i_z - w_atan;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cordic_polar_analyzer.sv
`default_nettype none
// ============================================================================
// Module      : cordic_polar_analyzer
// Description : Iterative vectoring-mode CORDIC converting a Cartesian sample
//               (x, y) into magnitude and phase. One micro-rotation per clock
//               followed by one gain-compensation/output cycle.
// Ports       : clk_i, rst_i (async, active-high)
//               x_i, y_i                  signed Q0.N_FRAC samples
//               data_in_valid_strobe_i    sample strobe
//               magnitude_o, phase_o      results (phase: full scale = [-pi,pi))
//               data_out_valid_strobe_o   one-cycle result strobe
//               busy_o                    conversion in progress
//               overrun_strobe_o          a strobe was dropped while busy
// Revision    : 1.0  initial release
// ============================================================================
module cordic_polar_analyzer
  import cordic_pkg::*;
#(
  parameter int N_FRAC = 7,
  parameter int N_ITER = N_FRAC + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic signed [N_FRAC:0] x_i,
  input  logic signed [N_FRAC:0] y_i,
  input  logic                 data_in_valid_strobe_i,
  output logic signed [N_FRAC:0] magnitude_o,
  output logic signed [N_FRAC:0] phase_o,
  output logic                 data_out_valid_strobe_o,
  output logic                 busy_o,
  output logic                 overrun_strobe_o
);

  localparam int W  = N_FRAC + 1;
  // Two guard bits: one for negating the most-negative sample, one for CORDIC growth
  localparam int IW = N_FRAC + 3;

  localparam logic [c_idx_w-1:0] c_last_iter = c_idx_w'(N_ITER - 1);
  localparam logic signed [IW-1:0] c_sat     = IW'(sat_pos(W));

  logic [1:0]            r_state;
  logic [c_idx_w-1:0]    r_iter;
  logic signed [IW-1:0]  r_x;
  logic signed [IW-1:0]  r_y;
  logic signed [W-1:0]   r_z;
  logic                  r_zero;
  logic                  r_busy;

  logic signed [IW-1:0]  w_x_ext;
  logic signed [IW-1:0]  w_y_ext;
  logic signed [IW-1:0]  w_x_nxt;
  logic signed [IW-1:0]  w_y_nxt;
  logic signed [W-1:0]   w_z_nxt;
  logic signed [IW-1:0]  w_mag;
  logic signed [W-1:0]   w_mag_sat;
  logic                  w_idle;

  assign w_idle  = (r_state == c_st_idle);
  assign w_x_ext = {{2{x_i[W-1]}}, x_i};
  assign w_y_ext = {{2{y_i[W-1]}}, y_i};

  cordic_vectoring_step #(
    .N_FRAC (N_FRAC),
    .IW     (IW)
  ) u_step (
    .i_x   (r_x),
    .i_y   (r_y),
    .i_z   (r_z),
    .i_idx (r_iter),
    .o_x   (w_x_nxt),
    .o_y   (w_y_nxt),
    .o_z   (w_z_nxt)
  );

  // Gain compensation: 1/2 + 1/8 - 1/64 - 1/512 = 0.60742
  assign w_mag = (r_x >>> c_gain_sh0) + (r_x >>> c_gain_sh1)
               - (r_x >>> c_gain_sh2) - (r_x >>> c_gain_sh3);

  always_comb begin
    w_mag_sat = w_mag[W-1:0];
    if (w_mag > c_sat) begin
      w_mag_sat = c_sat[W-1:0];
    end else if (w_mag[IW-1]) begin
      w_mag_sat = '0;
    end
  end

  assign busy_o = r_busy;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state                 <= c_st_idle;
      r_iter                  <= '0;
      r_x                     <= '0;
      r_y                     <= '0;
      r_z                     <= '0;
      r_zero                  <= 1'b0;
      r_busy                  <= 1'b0;
      magnitude_o             <= '0;
      phase_o                 <= '0;
      data_out_valid_strobe_o <= 1'b0;
      overrun_strobe_o        <= 1'b0;
    end else begin
      data_out_valid_strobe_o <= 1'b0;
      overrun_strobe_o        <= data_in_valid_strobe_i && !w_idle;
      case (r_state)
        c_st_idle: begin
          r_busy <= data_in_valid_strobe_i;
          if (data_in_valid_strobe_i) begin
            // Pre-rotate the left half-plane by pi so the iterations converge
            if (x_i[W-1]) begin
              r_x <= -w_x_ext;
              r_y <= -w_y_ext;
              r_z <= {1'b1, {(W-1){1'b0}}};
            end else begin
              r_x <= w_x_ext;
              r_y <= w_y_ext;
              r_z <= '0;
            end
            r_zero  <= (x_i == '0) && (y_i == '0);
            r_iter  <= '0;
            r_state <= c_st_iter;
          end
        end
        c_st_iter: begin
          r_x    <= w_x_nxt;
          r_y    <= w_y_nxt;
          r_z    <= w_z_nxt;
          r_iter <= r_iter + 1'b1;
          r_busy <= 1'b1;
          if (r_iter == c_last_iter) begin
            r_state <= c_st_scale;
          end
        end
        c_st_scale: begin
          // busy stays high through the result-strobe cycle
          r_busy                  <= 1'b1;
          magnitude_o             <= r_zero ? '0 : w_mag_sat;
          phase_o                 <= r_zero ? '0 : r_z;
          data_out_valid_strobe_o <= 1'b1;
          r_state                 <= c_st_idle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= c_st_idle;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/cordic_polar_analyzer.md
Name: cordic_polar_analyzer

Overview:
- Receive-side counterpart of the CORDIC sine generator: takes a Cartesian sample pair (x, y) and returns magnitude and phase.
- Uses an iterative vectoring-mode CORDIC: one micro-rotation per clock, followed by a gain-compensation step.
- Sits after demodulation/sampling logic; feeds amplitude/phase tracking.
- Phase format matches the generator's phase accumulator, so a generator output can be round-tripped.

Parameters:
- N_FRAC, 7: fractional bits. Samples and outputs are N_FRAC+1 bits signed, Q0.N_FRAC.
- N_ITER, N_FRAC+1: number of vectoring micro-rotations, range 1..N_FRAC+1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- x_i  in  N_FRAC+1  signed in-phase sample.
- y_i  in  N_FRAC+1  signed quadrature sample.
- data_in_valid_strobe_i  in  1  one-cycle pulse; x_i/y_i valid.
- magnitude_o  out  N_FRAC+1  signed magnitude, always >= 0, saturated.
- phase_o  out  N_FRAC+1  signed phase; -2^N_FRAC..2^N_FRAC-1 maps to [-pi, pi).
- data_out_valid_strobe_o  out  1  one-cycle pulse; results updated.
- busy_o  out  1  high while a conversion is in progress.
- overrun_strobe_o  out  1  one-cycle pulse; an input strobe was dropped.

Behaviour:
- Reset, asynchronous and immediate: state IDLE; all outputs 0; internal x/y/z/iteration counter cleared.
- Reset mid-conversion aborts it; no valid strobe is issued.
- States:
  - IDLE: on strobe, capture the inputs, go to ITER.
  - ITER: runs N_ITER cycles, then goes to SCALE.
  - SCALE: one cycle, registers outputs, returns to IDLE.
- Capture edge (pre-rotation), internal x/y width N_FRAC+3:
  - If x_i < 0: x = -x_i, y = -y_i, z = -2^N_FRAC (pi).
  - Otherwise: x = x_i, y = y_i, z = 0.
  - The guard bits absorb negation of the most-negative value and CORDIC growth.
- ITER, step i = 0..N_ITER-1, using arithmetic shifts:
  - If y >= 0: x += y>>>i, y -= x>>>i, z += ATAN[i].
  - Else: x -= y>>>i, y += x>>>i, z -= ATAN[i].
- z arithmetic: N_FRAC+1 bits, wraps modulo 2^(N_FRAC+1). Wrap is intended, since pi and -pi are the same angle.
- ATAN[i] = round(atan(2^-i)/pi * 2^N_FRAC). For N_FRAC=7: 32, 19, 10, 5, 3, 1, 1, 0.
- SCALE:
  - magnitude = (x>>>1) + (x>>>3) - (x>>>6) - (x>>>9), approximating K = 0.6074.
  - Saturate to 2^N_FRAC-1; phase_o = z.
  - Zero input (x_i = y_i = 0, flagged at capture): force magnitude_o = 0 and phase_o = 0.
- Latency: strobe sampled at edge E0; data_out_valid_strobe_o is high for exactly one cycle after edge E0+N_ITER+1, i.e. N_ITER+1 cycles.
- busy_o is high from the cycle after E0 until the strobe cycle, inclusive. Back-to-back throughput: one sample per N_ITER+2 cycles.
- A strobe arriving in the same cycle the valid strobe is high is accepted.
- A strobe arriving while busy (ITER or SCALE) is dropped. overrun_strobe_o pulses the next cycle; the conversion in progress is unaffected.
- Outputs hold their last values between strobes.

Decomposition:
- Package cordic_pkg holds:
  - ATAN table with 16 fractional bits; the module shifts right by 16-N_FRAC with rounding.
  - gain shift constants 1, 3, 6, 9.
  - state encoding IDLE/ITER/SCALE.
  - helper function sat_pos(width).
- One sub-module, cordic_vectoring_step: combinational single micro-rotation with inputs x, y, z, i and outputs x', y', z'. The top module holds the FSM, counter, registers and scaling.

Test Plan (N_FRAC=7, N_ITER=8; tolerance ±2 LSB unless noted):
- x=64, y=0 -> magnitude 64, phase 0; valid strobe exactly 9 cycles after the input strobe, one cycle wide.
- x=0, y=64 -> magnitude 64, phase 64. x=0, y=-64 -> phase -64.
- x=-64, y=0 -> magnitude 64, phase -128 or 127 (wrap accepted). x=64, y=64 -> magnitude 90, phase 32.
- x=-128, y=-128 -> magnitude saturates to 127, phase -96. x=y=0 -> magnitude 0, phase 0, exact.
- Second strobe 3 cycles after the first -> overrun_strobe_o pulses once; the first result is correct; only one valid strobe.
- rst_i asserted asynchronously mid-ITER -> outputs 0 with no clock edge; no valid strobe. A strobe after release gives a correct result.
- Round-trip check: sweep phase in steps of 8 at amplitude 100 using (100cos, 100sin) inputs -> phase error ≤2, magnitude error ≤3.
